// File: rtl/pwmdiv_pkg.sv
// pwmdiv_pkg: shared config type, channel state and config clamp for pwm_divider_mc
// Build option: define PWMDIV_POLARITY_EN to add a per-channel output polarity bit.
package pwmdiv_pkg;

    // Widest supported counter/config field; narrower W is zero-extended into it.
    localparam int WMAX = 32;

    typedef enum logic {IDLE, RUN} chan_st_e;

    typedef struct packed {
        logic [WMAX-1:0] total;
        logic [WMAX-1:0] high;
        logic [WMAX-1:0] phase;
`ifdef PWMDIV_POLARITY_EN
        logic            pol;
`endif
    } cfg_t;

    // Force a raw write into a consistent config: total >= 1, high <= total, phase < total.
    function automatic cfg_t clamp_cfg(input cfg_t raw);
        cfg_t c;
        c       = raw;
        c.total = (raw.total == '0) ? WMAX'(1) : raw.total;
        c.high  = (raw.high > c.total) ? c.total : raw.high;
        c.phase = (raw.phase >= c.total) ? c.total - 1'b1 : raw.phase;
        return c;
    endfunction

endpackage

// File: rtl/pwmdiv_chan.sv
// pwmdiv_chan: one PWM/divider channel with shadowed config applied at period boundaries
// Build option: PWMDIV_POLARITY_EN XORs the output with the active polarity bit.
module pwmdiv_chan import pwmdiv_pkg::*; #(
    parameter int W = 16
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic enable_i,
    input  logic wr_i,
    input  cfg_t cfg_i,
    output logic busy_o,
    output logic clk_out_o,
    output logic period_start_o
);

    chan_st_e        st_q;
    logic [W-1:0]    cnt_q;
    logic [WMAX-1:0] cnt_w;
    cfg_t            shadow_q, active_q;
    logic            acc_q, pend_q, clk_q, ps_q;
    logic            run, at_end, clk_d, ps_d;

    // A write is first captured (acc_q) and becomes pending one edge later;
    // the channel refuses further writes for the whole time either flag is set.
    assign busy_o = acc_q | pend_q;
    assign run    = (st_q == RUN);
    assign cnt_w  = WMAX'(cnt_q);
    assign at_end = (cnt_w == active_q.total - 1'b1);
`ifdef PWMDIV_POLARITY_EN
    assign clk_d  = (run && cnt_w < active_q.high) ^ active_q.pol;
`else
    assign clk_d  = run && cnt_w < active_q.high;
`endif
    assign ps_d   = run && cnt_q == '0;

    assign clk_out_o      = clk_q;
    assign period_start_o = ps_q;

    // Channel FSM: shadow capture, IDLE/RUN sequencing, counter and output flops.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            st_q     <= IDLE;
            cnt_q    <= '0;
            shadow_q <= '0;
            active_q <= '0;
            acc_q    <= 1'b0;
            pend_q   <= 1'b0;
            clk_q    <= 1'b0;
            ps_q     <= 1'b0;
        end else begin
            clk_q <= clk_d;
            ps_q  <= ps_d;
            acc_q <= wr_i;
            if (wr_i)
                shadow_q <= cfg_i;
            if (acc_q)
                pend_q <= 1'b1;
            if (st_q == IDLE) begin
                if (enable_i && pend_q) begin
                    active_q <= shadow_q;
                    pend_q   <= 1'b0;
                    cnt_q    <= W'(shadow_q.phase);
                    st_q     <= RUN;
                end else if (enable_i && active_q.total != '0) begin
                    cnt_q <= W'(active_q.phase);
                    st_q  <= RUN;
                end else begin
                    cnt_q <= '0;
                end
            end else if (!enable_i) begin
                cnt_q <= '0;
                st_q  <= IDLE;
            end else if (at_end) begin
                if (pend_q) begin
                    active_q <= shadow_q;
                    pend_q   <= 1'b0;
                end
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pwm_divider_mc.sv
// pwm_divider_mc: multi-channel programmable clock divider / PWM generator
// Build option: PWMDIV_POLARITY_EN adds the cfg_pol input and per-channel output polarity.
module pwm_divider_mc import pwmdiv_pkg::*; #(
    parameter int  NCH = 4,
    parameter int  W   = 16,
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk_in,
    input  logic           rst_n,
    input  logic [NCH-1:0] enable,
    input  logic           cfg_valid,
    output logic           cfg_ready,
    input  logic [CW-1:0]  cfg_ch,
    input  logic [W-1:0]   cfg_total,
    input  logic [W-1:0]   cfg_high,
    input  logic [W-1:0]   cfg_phase,
`ifdef PWMDIV_POLARITY_EN
    input  logic           cfg_pol,
`endif
    output logic [NCH-1:0] clk_out,
    output logic [NCH-1:0] period_start
);

    localparam int NP = 1 << CW;

    logic [NCH-1:0] busy;
    logic [NP-1:0]  busy_ext;
    cfg_t           raw, eff;

    // Widen the write fields into the shared config shape before clamping.
    always_comb begin
        raw       = '0;
        raw.total = WMAX'(cfg_total);
        raw.high  = WMAX'(cfg_high);
        raw.phase = WMAX'(cfg_phase);
`ifdef PWMDIV_POLARITY_EN
        raw.pol   = cfg_pol;
`endif
    end

    assign eff = clamp_cfg(raw);

    // Indices beyond NCH see a zero busy bit, so they are always ready and never captured.
    assign busy_ext  = NP'(busy);
    assign cfg_ready = !busy_ext[cfg_ch];

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        pwmdiv_chan #(.W(W)) u_chan (
            .clk_in         (clk_in),
            .rst_n          (rst_n),
            .enable_i       (enable[i]),
            .wr_i           (cfg_valid && cfg_ready && cfg_ch == CW'(i)),
            .cfg_i          (eff),
            .busy_o         (busy[i]),
            .clk_out_o      (clk_out[i]),
            .period_start_o (period_start[i])
        );
    end

endmodule

// File: doc/pwm_divider_mc.md
Name: pwm_divider_mc

Overview:
Multi-channel programmable clock divider and PWM generator. It is the parametrised successor to the team's single-channel duty-cycle divider.
- Adds per-channel period, high time and phase offset.
- Adds a valid/ready config port, so no free-running config sampling.
- Config changes are shadowed and applied glitch-free at period boundaries.
- Feeds timing strobes, LED/motor PWM and derived slow clocks from clk_in.

Parameters:
NCH, 4, number of independent output channels (1..16)
W, 16, counter and config field width in bits

Ports:
clk_in  input  1  system clock; all logic on its rising edge
rst_n  input  1  asynchronous, active-low reset
enable  input  NCH  per-channel run enable, level-sensitive
cfg_valid  input  1  config write request
cfg_ready  output  1  config write can be accepted this cycle
cfg_ch  input  max(1,$clog2(NCH))  target channel index
cfg_total  input  W  period in clk_in cycles
cfg_high  input  W  high time in clk_in cycles
cfg_phase  input  W  counter start value on (re)start and apply
clk_out  output  NCH  registered divided/PWM outputs
period_start  output  NCH  one-cycle pulse, registered with clk_out, when the sampled counter is 0

Behaviour:
- Reset (async, immediate): clk_out=0, period_start=0, all counters=0, active_total=0, pending=0, every channel in IDLE. cfg_ready is combinational: cfg_ready = !pending[cfg_ch]. It is 1 after reset.
- Accept: on a rising edge with cfg_valid & cfg_ready, capture the clamped config into the shadow of channel cfg_ch and set pending. cfg_ch >= NCH is ignored (no capture), and cfg_ready is 1 for such indices.
- Clamping at capture:
  - total_eff = (cfg_total==0) ? 1 : cfg_total
  - high_eff = min(cfg_high, total_eff)
  - phase_eff = (cfg_phase >= total_eff) ? total_eff-1 : cfg_phase
- Per-channel FSM has states IDLE and RUN.
- IDLE:
  - If enable & pending: load active from shadow, clear pending, counter<=phase_eff, go to RUN.
  - If enable & !pending & active_total!=0: counter<=active_phase, go to RUN.
  - Otherwise stay in IDLE with counter=0.
- RUN, enable high:
  - If counter == active_total-1: this is the boundary. If pending, load active from shadow and clear pending. Then counter<=0.
  - Otherwise counter<=counter+1.
  - active_total >= 1 always holds in RUN, so the W-bit subtract never wraps.
- RUN, enable low: next edge goes to IDLE with counter=0. Active config is retained.
- Outputs, registered each edge:
  - clk_out[i] <= RUN & (counter < active_high)
  - period_start[i] <= RUN & (counter==0)
  - In IDLE, both are 0 on the next edge.
- Latency: accept at edge E0 → pending at E1 → load at E2 (IDLE) or at the boundary (RUN) → clk_out reflects the new config one edge after load.
- Boundary apply does not corrupt the current period: the old period completes fully before new values take effect.
- Writes to a different channel are independent of pending on other channels.
- high_eff == total_eff gives constant 1. high_eff == 0 gives constant 0.
- Reset asserted mid-period aborts immediately. There is no partial-period completion after release.

Optional Feature:
Macro PWMDIV_POLARITY_EN.
- Defined: adds input cfg_pol (1 bit), captured with the config. clk_out[i] is XORed with the channel's active polarity. The polarity change applies at the same boundary as the other config fields. In IDLE the output sits at the polarity level, not 0.
- Undefined: no cfg_pol port; polarity is fixed non-inverted.

Decomposition:
- Package pwmdiv_pkg holds:
  - config struct typedef {total, high, phase[, pol]}
  - channel state enum {IDLE, RUN}
  - clamp function producing the _eff values
- Sub-module pwmdiv_chan holds one channel's FSM, counter, shadow/active registers and output flops.
- The top generates NCH instances and does cfg_ch decode and cfg_ready muxing.

Test Plan:
1. Reset: hold rst_n=0 → clk_out=0, period_start=0, cfg_ready=1. Release and leave enable=0 → outputs stay 0.
2. ch0 total=4 high=1 phase=0, enable[0]=1 → clk_out[0] repeats 1,0,0,0. period_start[0] is high every 4th cycle, aligned with the 1. First high comes 3 edges after accept.
3. ch2 total=0 high=5 → clamped to total=1 high=1 → clk_out[2] constant 1 and period_start[2] constant 1. Then write high=0 → constant 0 from the next boundary.
4. ch1 running total=10 high=5. Write total=4 high=2 at counter=3 → cfg_ready low for cfg_ch=1 until the boundary. The second write is held off. The current 10-cycle period completes, then the pattern is 1,1,0,0.
5. ch0 and ch3 both total=8 high=4, phases 0 and 4, enabled on the same edge → outputs are 180° apart, with period_start pulses 4 cycles apart.
6. Drop enable[1] at counter=6 → clk_out[1]=0 next edge. Re-enable → restart at the active phase. Pulse rst_n low mid-run → immediate reset values.
